// File: rtl/sorcerer_pkg.sv
// sorcerer_pkg: shared state/requester types and RAM bank selects for the Sorcerer RAM arbiter.
package sorcerer_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} arb_state_t;
   typedef enum logic [1:0] {REQ_CPU, REQ_DMA, REQ_TAPE} req_id_t;
   localparam logic RAM_BANK_CPU  = 1'b0;
   localparam logic RAM_BANK_TAPE = 1'b1;
endpackage

// File: rtl/sorcerer_tape_fifo.sv
// sorcerer_tape_fifo: circular byte FIFO holding prefetched tape-image bytes.
module sorcerer_tape_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       CLK12,
   input  logic       RESET,
   input  logic       push,
   input  logic       pop,
   input  logic       flush,
   input  logic [7:0] wdata,
   output logic [7:0] data,
   output logic       empty,
   output logic       full
);
   localparam int AW = $clog2(DEPTH);
   logic [7:0] mem [DEPTH];
   logic [AW-1:0] head, tail;
   logic [AW:0] count;
   logic do_push, do_pop;
   assign empty = count == '0;
   assign full = count == (AW+1)'(DEPTH);
   assign do_push = push && !full;
   assign do_pop = pop && !empty;
   assign data = mem[head];
   always_ff @(posedge CLK12) begin
      if (RESET) begin
         head <= '0;
         tail <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         head <= '0;
         tail <= '0;
         count <= '0;
      end else begin
         if (do_push) mem[tail] <= wdata;
         tail <= do_push ? tail + AW'(1) : tail;
         head <= do_pop ? head + AW'(1) : head;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/sorcerer_ram_arb.sv
// sorcerer_ram_arb: prioritised CPU > DMA > tape access slots on the shared 128 KB Sorcerer RAM.
// Define SORCERER_TAPE_FIFO_EN for a TAPE_FIFO_DEPTH-entry prefetch FIFO; otherwise one holding register.
module sorcerer_ram_arb
   import sorcerer_pkg::*;
#(
   parameter int RAM_LAT         = 2,
   parameter int TAPE_FIFO_DEPTH = 4
) (
   input  logic        CLK12,
   input  logic        RESET,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [14:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic [7:0]  cpu_rdata,
   output logic        cpu_ack,
   output logic        cpu_wait_n,
   input  logic        dma_req,
   input  logic [15:0] dma_addr,
   input  logic [7:0]  dma_wdata,
   output logic        dma_ack,
   input  logic        tape_arm,
   input  logic [15:0] tape_end,
   input  logic        tape_pop,
   output logic [7:0]  tape_data,
   output logic        tape_ready,
   output logic [16:0] RAM_ADDR,
   output logic        RAM_RD,
   output logic        RAM_WR,
   output logic [7:0]  RAM_DIN,
   input  logic [7:0]  RAM_DOUT
);
   localparam int CW = $clog2(RAM_LAT + 1);
   arb_state_t state, nxt;
   req_id_t req_id, gnt;
   logic [CW-1:0] cnt;
   logic [7:0] rdata;
   logic [15:0] rd_ptr, end_ptr;
   logic active, stale, start, last, room, push;
   assign last = state == ST_ACCESS && cnt == CW'(RAM_LAT - 1);
   assign push = state == ST_DONE && req_id == REQ_TAPE && !stale && !tape_arm;
   assign cpu_rdata = rdata;
   always_ff @(posedge CLK12) state <= RESET ? ST_IDLE : nxt;
   always_comb begin
      start = state == ST_IDLE && (cpu_req || dma_req || (active && room));
      gnt = cpu_req ? REQ_CPU : dma_req ? REQ_DMA : REQ_TAPE;
      nxt = start ? ST_ACCESS : last ? ST_DONE : state == ST_DONE ? ST_IDLE : state;
   end
   always_ff @(posedge CLK12) begin
      if (RESET) begin
         cnt <= '0;
         req_id <= REQ_CPU;
         rdata <= '0;
         RAM_ADDR <= '0;
         RAM_DIN <= '0;
         RAM_RD <= 1'b0;
         RAM_WR <= 1'b0;
         cpu_ack <= 1'b0;
         dma_ack <= 1'b0;
         cpu_wait_n <= 1'b1;
      end else begin
         cnt <= state == ST_ACCESS ? cnt + CW'(1) : '0;
         if (start) begin
            req_id <= gnt;
            RAM_ADDR <= gnt == REQ_CPU ? {RAM_BANK_CPU, 1'b0, cpu_addr}
                                       : {RAM_BANK_TAPE, gnt == REQ_DMA ? dma_addr : rd_ptr};
            RAM_DIN <= gnt == REQ_CPU ? cpu_wdata : dma_wdata;
         end
         RAM_RD <= start ? (gnt == REQ_CPU ? !cpu_we : gnt == REQ_TAPE) : RAM_RD && !last;
         RAM_WR <= start ? (gnt == REQ_CPU ? cpu_we : gnt == REQ_DMA) : RAM_WR && !last;
         if (last && RAM_RD) rdata <= RAM_DOUT;
         cpu_ack <= last && req_id == REQ_CPU;
         dma_ack <= last && req_id == REQ_DMA;
         cpu_wait_n <= cpu_ack || !cpu_req;
      end
   end
   // A re-arm while a tape fetch is granted or in flight marks that fetch's byte as stale.
   always_ff @(posedge CLK12) begin
      if (RESET) begin
         rd_ptr <= '0;
         end_ptr <= '0;
         active <= 1'b0;
         stale <= 1'b0;
      end else begin
         stale <= start && gnt == REQ_TAPE ? tape_arm : stale || tape_arm;
         if (tape_arm) begin
            rd_ptr <= '0;
            end_ptr <= tape_end;
            active <= 1'b1;
         end else if (push) begin
            active <= rd_ptr != end_ptr;
            rd_ptr <= rd_ptr + 16'd1;
         end
      end
   end
`ifdef SORCERER_TAPE_FIFO_EN
   logic full, empty;
   sorcerer_tape_fifo #(.DEPTH(TAPE_FIFO_DEPTH)) u_fifo (
      .CLK12(CLK12),
      .RESET(RESET),
      .push(push),
      .pop(tape_pop),
      .flush(tape_arm),
      .wdata(rdata),
      .data(tape_data),
      .empty(empty),
      .full(full)
   );
   assign room = !full;
   assign tape_ready = !empty;
`else
   logic hold_valid;
   assign room = TAPE_FIFO_DEPTH > 0 && !hold_valid;
   assign tape_ready = hold_valid;
   always_ff @(posedge CLK12) begin
      if (RESET) begin
         hold_valid <= 1'b0;
         tape_data <= '0;
      end else begin
         hold_valid <= push || (hold_valid && !tape_pop && !tape_arm);
         if (push) tape_data <= rdata;
      end
   end
`endif
endmodule
